fetch_controller: RTL

Instruction-fetch sequencer that owns the program counter and drives the 128-word instruction memory, which has a word-indexed address and a one-cycle registered read. It issues word addresses, absorbs the memory's read latency with a 2-entry buffer, and presents instructions to decode over a valid/ready handshake. It also handles branch/jump redirects with flush, and latches a fault on illegal PCs.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_skid_fifo.sv | 35 +++
 rtl/fetch_controller.sv | 80 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer
package fetch_pkg;
    typedef enum logic {RUN, FAULT} fetch_state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
    localparam logic [31:0] INST_BYTES = 32'd4;
    localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry {pc, inst} buffer absorbing the one-cycle memory latency
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        push,
    input  logic        pop,
    input  logic [63:0] din,
    output logic [63:0] dout,
    output logic [1:0]  count
);
    logic [63:0] slots [BUF_DEPTH];
    logic rd_ptr, wr_idx, do_push, do_pop;
    assign do_pop = pop & (count != 2'd0);
    assign do_push = push & ((count != 2'(BUF_DEPTH)) | do_pop);
    // When full and popping, the write lands in the slot being vacated
    assign wr_idx = rd_ptr ^ count[0];
    assign dout = slots[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots <= '{default: '0};
            rd_ptr <= 1'b0;
            count <= 2'd0;
        end else if (clear) begin
            rd_ptr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (do_push) slots[wr_idx] <= din;
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: PC sequencer with redirect/flush, latency buffer and sticky illegal-PC fault
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] IMEM_DEPTH = 32'd128
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        run_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);
    fetch_state_t state;
    fetch_entry_t resp, head;
    logic [31:0] fetch_pc, req_pc;
    logic [1:0] count;
    logic inflight, req_epoch, epoch;
    logic pop, redirect, misaligned, in_range, opportunity, issue, push;
    assign imem_pc = {2'b0, fetch_pc[31:2]};
    assign pop = out_valid & out_ready;
    assign redirect = redirect_valid & (state == RUN);
    assign misaligned = redirect_pc[1:0] != 2'b0;
    assign in_range = imem_pc < IMEM_DEPTH;
    // Room exists if what is buffered plus what is in flight, net of this pop, leaves a slot
    assign opportunity = (state == RUN) & run_en & !redirect_valid &
                         (({1'b0, count} + {2'b0, inflight}) < (3'(BUF_DEPTH) + {2'b0, pop}));
    assign issue = opportunity & in_range;
    assign push = inflight & (req_epoch == epoch);
    assign resp = '{pc: req_pc, inst: imem_inst};
    assign out_valid = count != 2'd0;
    assign out_pc = head.pc;
    assign out_inst = head.inst;
    fetch_skid_fifo u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect),
        .push  (push),
        .pop   (pop),
        .din   (resp),
        .dout  (head),
        .count (count)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            fetch_pc <= RESET_PC;
            req_pc <= '0;
            inflight <= 1'b0;
            req_epoch <= 1'b0;
            epoch <= 1'b0;
            fault <= 1'b0;
            fault_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                req_pc <= fetch_pc;
                req_epoch <= epoch;
                fetch_pc <= fetch_pc + INST_BYTES;
            end
            if (redirect) begin
                epoch <= ~epoch;
                fetch_pc <= redirect_pc;
            end
            if ((redirect & misaligned) | (opportunity & !in_range)) begin
                state <= FAULT;
                fault <= 1'b1;
                fault_pc <= redirect ? redirect_pc : fetch_pc;
            end
        end
    end
endmodule
